alu_mc: RTL and testbench

//  Parametrised multi-cycle ALU; successor to the single-cycle 32-bit ALU.

---
 rtl/alu_mc_pkg.sv | 48 ++++
 rtl/alu_mc_muldiv.sv | 114 +++++++++++
 rtl/alu_mc.sv | 181 ++++++++++++++++++
 tb/tb_alu_mc.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU.
//   op_t     : 4-bit opcode encodings
//   state_t  : control FSM states
//   is_multicycle / is_div_op : opcode classification helpers
// Optional feature macro: ALU_MC_DIV_EN (DIVU/REMU become iterative ops).
package alu_mc_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_ADC  = 4'd2,
    OP_SBC  = 4'd3,
    OP_NOT  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_LSL  = 4'd8,
    OP_LSR  = 4'd9,
    OP_ASR  = 4'd10,
    OP_ROR  = 4'd11,
    OP_MUL  = 4'd12,
    OP_MULH = 4'd13,
    OP_DIVU = 4'd14,
    OP_REMU = 4'd15
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_div_op(input op_t op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  // Without the divider, DIVU/REMU complete in one cycle as illegal ops.
  function automatic logic is_multicycle(input op_t op);
    logic mc;
    mc = (op == OP_MUL) || (op == OP_MULH);
`ifdef ALU_MC_DIV_EN
    mc = mc || is_div_op(op);
`endif
    return mc;
  endfunction

endpackage

// File: rtl/alu_mc_muldiv.sv
// Iterative shift-add multiplier and (optional) restoring divider.
// Both share one WIDTH-bit adder and a 2*WIDTH accumulator {hi, lo}.
//   start_i  : load operands (one-cycle pulse)
//   is_div_i : operation is DIVU/REMU
//   sel_hi_i : return high half (MULH product / REMU remainder)
//   a_i/b_i  : operands
//   done_o   : high during the final iteration cycle; result_o/c_o are
//              valid in that same cycle (taken from the next accumulator)
// Optional feature macro: ALU_MC_DIV_EN (divider logic present).
module alu_mc_muldiv #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic             sel_hi_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             c_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q;
  logic [SHW-1:0]     cnt_q;
  logic               active_q, hi_q;
  logic [WIDTH-1:0]   hi_w, lo_w, add_x, add_y, sum;
  logic               add_ci, cout, load;

  assign hi_w = acc_q[2*WIDTH-1:WIDTH];
  assign lo_w = acc_q[WIDTH-1:0];

`ifdef ALU_MC_DIV_EN
  logic div_q, zero_q, trial_ok;
  assign load = start_i;
`else
  // No divider: a divide request never starts the engine.
  assign load = start_i & ~is_div_i;
`endif

  // Shared adder operand selection.
  always_comb begin
    add_x  = hi_w;
    add_y  = lo_w[0] ? opnd_q : '0;
    add_ci = 1'b0;
`ifdef ALU_MC_DIV_EN
    if (div_q) begin
      // Trial subtract of divisor from the left-shifted partial remainder.
      add_x  = {hi_w[WIDTH-2:0], lo_w[WIDTH-1]};
      add_y  = ~opnd_q;
      add_ci = 1'b1;
    end
`endif
  end

  assign {cout, sum} = {1'b0, add_x} + {1'b0, add_y} + (WIDTH+1)'(add_ci);

  always_comb begin
    // Multiply: add multiplicand when multiplier LSB set, shift right.
    acc_d = {cout, sum, lo_w[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
    // The shifted remainder has an implicit bit WIDTH (hi_w MSB); the
    // subtraction succeeds when that bit or the adder carry is set.
    trial_ok = hi_w[WIDTH-1] | cout;
    if (div_q) acc_d = {trial_ok ? sum : add_x, lo_w[WIDTH-2:0], trial_ok};
`endif
  end

  assign done_o   = active_q && (cnt_q == SHW'(WIDTH-1));
  assign result_o = hi_q ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];

  always_comb begin
    c_o = hi_q ? 1'b0 : (|acc_d[2*WIDTH-1:WIDTH]);
`ifdef ALU_MC_DIV_EN
    if (div_q) c_o = zero_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      hi_q     <= 1'b0;
`ifdef ALU_MC_DIV_EN
      div_q    <= 1'b0;
      zero_q   <= 1'b0;
`endif
    end else if (load) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      hi_q     <= sel_hi_i;
      acc_q    <= {{WIDTH{1'b0}}, b_i};
      opnd_q   <= a_i;
`ifdef ALU_MC_DIV_EN
      div_q    <= is_div_i;
      zero_q   <= (b_i == '0);
      if (is_div_i) begin
        acc_q  <= {{WIDTH{1'b0}}, a_i};
        opnd_q <= b_i;
      end
`endif
    end else if (active_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops plus iterative
// multiply (and divide when ALU_MC_DIV_EN is defined).
// Ports:
//   clk, rst_n (async, active-low)
//   in_valid/in_ready, op, arg_a, arg_b, c_in : operation request
//   out_valid/out_ready, result, z, c, n      : registered result + flags
//   busy      : multi-cycle op in progress
//   dbg_state : current FSM state (alu_mc_pkg::state_t encoding)
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high; a source holds valid and its payload until that edge, and the
// result side holds result/flags stable while out_valid & !out_ready.
// Optional feature macro: ALU_MC_DIV_EN.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] arg_a,
  input  logic [WIDTH-1:0] arg_b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             c,
  output logic             n,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  state_t           state_q, state_d;
  op_t              op_e;
  logic             accept, mc;
  logic [WIDTH-1:0] res_q, res_d, sc_res, md_res;
  logic             c_q, c_d, z_q, n_q, sc_c, md_c, md_done;
  logic [WIDTH:0]   wide;
  logic [SHW-1:0]   shamt;
  logic [SHW:0]     rsh;

  assign op_e   = op_t'(op);
  assign mc     = is_multicycle(op_e);
  assign accept = in_valid & in_ready;
  assign shamt  = arg_b[SHW-1:0];
  assign rsh    = (SHW+1)'(WIDTH) - {1'b0, shamt};

  // Control FSM.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = mc ? (is_div_op(op_e) ? DIV : MUL) : DONE;
      end
      MUL, DIV: begin
        if (md_done) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) state_d = mc ? (is_div_op(op_e) ? DIV : MUL) : DONE;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle datapath.
  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    wide   = '0;
    case (op_e)
      OP_ADD: begin
        wide = {1'b0, arg_a} + {1'b0, arg_b};
        sc_res = wide[WIDTH-1:0]; sc_c = wide[WIDTH];
      end
      OP_SUB: begin
        wide = {1'b0, arg_a} - {1'b0, arg_b};
        sc_res = wide[WIDTH-1:0]; sc_c = wide[WIDTH];
      end
      OP_ADC: begin
        wide = {1'b0, arg_a} + {1'b0, arg_b} + (WIDTH+1)'(c_in);
        sc_res = wide[WIDTH-1:0]; sc_c = wide[WIDTH];
      end
      OP_SBC: begin
        wide = {1'b0, arg_a} - {1'b0, arg_b} - (WIDTH+1)'(c_in);
        sc_res = wide[WIDTH-1:0]; sc_c = wide[WIDTH];
      end
      OP_NOT: sc_res = ~arg_a;
      OP_AND: sc_res = arg_a & arg_b;
      OP_OR:  sc_res = arg_a | arg_b;
      OP_XOR: sc_res = arg_a ^ arg_b;
      // Shifts run one bit wider so the last bit out lands in the extra
      // bit; a zero shift leaves that bit at 0.
      OP_LSL: begin
        wide = {1'b0, arg_a} << shamt;
        sc_res = wide[WIDTH-1:0]; sc_c = wide[WIDTH];
      end
      OP_LSR: begin
        wide = {arg_a, 1'b0} >> shamt;
        sc_res = wide[WIDTH:1]; sc_c = wide[0];
      end
      OP_ASR: begin
        wide = $signed({arg_a, 1'b0}) >>> shamt;
        sc_res = wide[WIDTH:1]; sc_c = wide[0];
      end
      OP_ROR: begin
        // For shamt==0, rsh==WIDTH and the left term vanishes.
        sc_res = (arg_a >> shamt) | (arg_a << rsh);
        sc_c   = (shamt != '0) & sc_res[WIDTH-1];
      end
      // Only reached here when no divider is built: illegal-op result.
      OP_DIVU, OP_REMU: begin
        sc_res = '0; sc_c = 1'b1;
      end
      default: begin
        sc_res = '0; sc_c = 1'b0;
      end
    endcase
  end

  alu_mc_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (accept & mc),
    .is_div_i (is_div_op(op_e)),
    .sel_hi_i ((op_e == OP_MULH) || (op_e == OP_REMU)),
    .a_i      (arg_a),
    .b_i      (arg_b),
    .done_o   (md_done),
    .result_o (md_res),
    .c_o      (md_c)
  );

  // Output registers update only on a single-cycle accept or on the final
  // iteration, so they hold while the consumer stalls.
  always_comb begin
    res_d = res_q;
    c_d   = c_q;
    if (accept && !mc) begin
      res_d = sc_res;
      c_d   = sc_c;
    end else if (md_done) begin
      res_d = md_res;
      c_d   = md_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      c_q     <= c_d;
      z_q     <= (res_d == '0);
      n_q     <= res_d[WIDTH-1];
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == MUL) || (state_q == DIV);
  assign result    = res_q;
  assign z         = z_q;
  assign c         = c_q;
  assign n         = n_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32).
module tb_alu_mc;

  localparam int W   = 32;
  localparam int SHW = $clog2(W);
  localparam longint unsigned MAXV = 64'hFFFF_FFFF;

  logic         clk, rst_n;
  logic         in_valid, in_ready, c_in;
  logic [3:0]   op;
  logic [W-1:0] arg_a, arg_b, result;
  logic         out_valid, out_ready, z, c, n, busy;
  logic [1:0]   dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bit   rr_en     = 1'b0;
  logic ready_cmd = 1'b1;

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .arg_a     (arg_a),
    .arg_b     (arg_b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .z         (z),
    .c         (c),
    .n         (n),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic bit ref_mc(input logic [3:0] o);
`ifdef ALU_MC_DIV_EN
    return o >= 4'd12;
`else
    return (o == 4'd12) || (o == 4'd13);
`endif
  endfunction

  function automatic int ref_lat(input logic [3:0] o);
    return ref_mc(o) ? W + 1 : 1;
  endfunction

  // Returns {c, result}.
  function automatic logic [W:0] ref_alu(input logic [3:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic ci);
    longint unsigned ua, ub, p;
    int              s;
    logic [W-1:0]    r;
    logic            cf;
    ua = a; ub = b; s = int'(b) & (W - 1);
    r = '0; cf = 1'b0; p = 0;
    case (o)
      4'd0:  begin p = ua + ub;      r = p[W-1:0]; cf = p > MAXV; end
      4'd1:  begin r = a - b;        cf = ua < ub; end
      4'd2:  begin p = ua + ub + ci; r = p[W-1:0]; cf = p > MAXV; end
      4'd3:  begin r = a - b - W'(ci); cf = ua < ub + ci; end
      4'd4:  r = ~a;
      4'd5:  r = a & b;
      4'd6:  r = a | b;
      4'd7:  r = a ^ b;
      4'd8:  begin r = a << s; cf = (s != 0) && (((ua >> (W - s)) & 1) != 0); end
      4'd9:  begin r = a >> s; cf = (s != 0) && a[s-1]; end
      4'd10: begin r = W'($signed(a) >>> s); cf = (s != 0) && a[s-1]; end
      4'd11: begin
        p = (ua >> s) | (ua << (W - s));
        r = p[W-1:0];
        cf = (s != 0) && r[W-1];
      end
      4'd12: begin p = ua * ub; r = p[W-1:0]; cf = (p >> W) != 0; end
      4'd13: begin p = ua * ub; r = p[2*W-1:W]; cf = 1'b0; end
      default: begin
`ifdef ALU_MC_DIV_EN
        if (ub == 0) begin
          r  = (o == 4'd14) ? {W{1'b1}} : a;
          cf = 1'b1;
        end else begin
          p  = (o == 4'd14) ? ua / ub : ua % ub;
          r  = p[W-1:0];
          cf = 1'b0;
        end
`else
        r = '0; cf = 1'b1;
`endif
      end
    endcase
    return {cf, r};
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: one entry per accepted op.
  logic [W:0] exp_q[$];
  int         due_q[$];
  int         acc_q[$];
  bit         mc_q[$];

  initial begin
    bit           ev, eb;
    logic [W-1:0] er;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete(); due_q.delete(); acc_q.delete(); mc_q.delete();
      end else begin
        ev = (exp_q.size() > 0) && (cyc >= due_q[0]);
        eb = (exp_q.size() > 0) && mc_q[0] && (cyc > acc_q[0]) && (cyc < due_q[0]);
        chk("out_valid", out_valid, ev);
        chk("busy", busy, eb);
        chk("in_ready", in_ready, !eb && (!ev || out_ready));
        if (ev) begin
          er = exp_q[0][W-1:0];
          chk("result", result, er);
          chk("c_flag", c, exp_q[0][W]);
          chk("z_flag", z, er == '0);
          chk("n_flag", n, er[W-1]);
          if (out_ready) begin
            void'(exp_q.pop_front()); void'(due_q.pop_front());
            void'(acc_q.pop_front()); void'(mc_q.pop_front());
          end
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(ref_alu(op, arg_a, arg_b, c_in));
          acc_q.push_back(cyc);
          due_q.push_back(cyc + ref_lat(op));
          mc_q.push_back(ref_mc(op));
        end
      end
    end
  end

  // ---------------- drivers ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = rr_en ? ($urandom_range(0, 3) != 0) : ready_cmd;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci);
    int k;
    k = 0;
    op = o; arg_a = a; arg_b = b; c_in = ci; in_valid = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 200);
    chk("accept_wait", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pin(input string name, input logic [3:0] o, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic ci, input logic [W:0] expv);
    chk(name, ref_alu(o, a, b, ci), expv);
    send(o, a, b, ci);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return {W{1'b1}};
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int t0;
    rst_n = 1'b0; in_valid = 1'b0; op = '0; arg_a = '0; arg_b = '0; c_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_z", z, 0);
    chk("rst_c", c, 0);
    chk("rst_n_flag", n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_state_idle", dbg_state, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    chk("lat_add", ref_lat(4'd0), 1);
    chk("lat_mul", ref_lat(4'd12), 33);

    pin("pin_add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 33'h1_0000_0000);
    pin("pin_sbc", 4'd3, 32'd5, 32'd5, 1'b1, 33'h1_FFFF_FFFF);
    pin("pin_lsl", 4'd8, 32'h8000_0001, 32'd1, 1'b0, 33'h1_0000_0002);
    pin("pin_asr", 4'd10, 32'h8000_0000, 32'd31, 1'b0, 33'h0_FFFF_FFFF);
    pin("pin_ror", 4'd11, 32'd1, 32'd1, 1'b0, 33'h1_8000_0000);
    pin("pin_lsr0", 4'd9, 32'h1234, 32'd0, 1'b0, 33'h0_0000_1234);
    pin("pin_ror0", 4'd11, 32'hA5, 32'd32, 1'b0, 33'h0_0000_00A5);
    pin("pin_mul", 4'd12, 32'h1_0000, 32'h1_0000, 1'b0, 33'h1_0000_0000);
    pin("pin_mulh", 4'd13, 32'h1_0000, 32'h1_0000, 1'b0, 33'h0_0000_0001);
`ifdef ALU_MC_DIV_EN
    pin("pin_divu", 4'd14, 32'd100, 32'd7, 1'b0, 33'h0_0000_000E);
    pin("pin_remu", 4'd15, 32'd100, 32'd7, 1'b0, 33'h0_0000_0002);
    pin("pin_div0", 4'd14, 32'd9, 32'd0, 1'b0, 33'h1_FFFF_FFFF);
    pin("pin_rem0", 4'd15, 32'd9, 32'd0, 1'b0, 33'h1_0000_0009);
`else
    pin("pin_divu_ill", 4'd14, 32'd100, 32'd7, 1'b0, 33'h1_0000_0000);
    pin("pin_remu_ill", 4'd15, 32'd100, 32'd7, 1'b0, 33'h1_0000_0000);
`endif
    drain();

    // Stalled consumer: result held, no new accept.
    ready_cmd = 1'b0;
    send(4'd0, 32'd3, 32'd4, 1'b0);
    in_valid = 1'b1; op = 4'd7; arg_a = 32'hF0F0; arg_b = 32'h0FF0; c_in = 1'b0;
    repeat (6) @(negedge clk);
    chk("stall_in_ready", in_ready, 0);
    @(posedge clk); #1;
    ready_cmd = 1'b1;
    in_valid = 1'b0;
    drain();

    // Back-to-back ADD stream: one accept per cycle.
    t0 = cyc;
    for (int i = 0; i < 8; i++) send(4'd0, $urandom, $urandom, 1'b0);
    chk("stream_cycles", cyc - t0, 8);
    drain();

    // Reset in the middle of a multiply.
    send(4'd12, 32'h1_0000, 32'h1_0000, 1'b0);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_flags", {z, c, n}, 3'b000);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    repeat (40) @(negedge clk);
    @(posedge clk); #1;

    // Randomized traffic with a randomly stalling consumer.
    rr_en = 1'b1;
    for (int i = 0; i < 150; i++)
      send(4'($urandom_range(0, 15)), rnd_val(), rnd_val(), 1'($urandom_range(0, 1)));
    rr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
